// File: rtl/exec_mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute/memory half of the integer pipeline:
// opcode and funct encodings, the memory access size enum, the word indices
// watched by the optional memory probes, and small opcode classifiers.
// -----------------------------------------------------------------------------
package exec_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_LUI   = 6'd3;
  localparam logic [5:0] OP_ANDI  = 6'd4;
  localparam logic [5:0] OP_ORI   = 6'd5;
  localparam logic [5:0] OP_XORI  = 6'd6;
  localparam logic [5:0] OP_LW    = 6'd16;
  localparam logic [5:0] OP_LH    = 6'd18;
  localparam logic [5:0] OP_LB    = 6'd20;
  localparam logic [5:0] OP_SW    = 6'd24;
  localparam logic [5:0] OP_SH    = 6'd26;
  localparam logic [5:0] OP_SB    = 6'd28;
  localparam logic [5:0] OP_JAL   = 6'd41;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd2;
  localparam logic [5:0] FN_AND = 6'd8;
  localparam logic [5:0] FN_OR  = 6'd9;
  localparam logic [5:0] FN_XOR = 6'd10;
  localparam logic [5:0] FN_NOR = 6'd11;
  localparam logic [5:0] FN_SLL = 6'd16;
  localparam logic [5:0] FN_SRL = 6'd17;
  localparam logic [5:0] FN_SRA = 6'd18;

  // Data-memory words exposed by the optional probe outputs
  localparam int DM_PROBE_WORD0 = 133;  // byte address 532
  localparam int DM_PROBE_WORD1 = 144;  // byte address 576
  localparam int DM_PROBE_WORD2 = 225;  // byte address 900

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE,
    SZ_NONE
  } size_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic size_e mem_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return SZ_WORD;
      OP_LH, OP_SH: return SZ_HALF;
      OP_LB, OP_SB: return SZ_BYTE;
      default:      return SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/exec_mem_stage_dm_lane.sv
// -----------------------------------------------------------------------------
// dm_lane
// One byte lane of the data memory: 8 bits x 2**AW entries, synchronous write,
// asynchronous read. NRD independent read ports (port 0 is the pipeline read,
// any further ports serve fixed-address observers).
//
// Ports:
//   sysclk   in   clock, rising edge
//   we_i     in   write enable, commits at the rising edge
//   waddr_i  in   AW-bit write index
//   wdata_i  in   8-bit write data
//   raddr_i  in   NRD x AW-bit read indices
//   rdata_o  out  NRD x 8-bit read data (combinational)
// -----------------------------------------------------------------------------
module dm_lane #(
  parameter int AW  = 8,
  parameter int NRD = 1
) (
  input  logic                    sysclk,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [7:0]              wdata_i,
  input  logic [NRD-1:0][AW-1:0]  raddr_i,
  output logic [NRD-1:0][7:0]     rdata_o
);

  logic [7:0] mem_q [2**AW];

  // NOTE: the array has no reset branch on purpose; clearing a RAM on reset
  // would turn it into a flop bank. Contents start at zero from device
  // configuration and are left untouched by cpu_resetn.
  always_ff @(posedge sysclk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    assign rdata_o[r] = mem_q[raddr_i[r]];
  end

endmodule

// File: rtl/exec_mem_stage.sv
// -----------------------------------------------------------------------------
// exec_mem_stage
// Execute (E1) and memory (E2) stages of the 5-stage integer pipeline.
// E1 is a combinational ALU whose result/destination are also exported for
// forwarding. An E1->E2 register follows; E2 holds a 2**DM_AW-word data memory
// built from four byte lanes and the write-back result mux.
//
// Ports:
//   sysclk, cpu_resetn        clock (rising edge), async active-low reset
//   pc_e1, op_e1, rt_e1,      E1 instruction fields; aux_e1 = {shamt, funct}
//   rd_e1, aux_e1
//   os_e1, ot_e1              forwarded rs / rt operands (ot = store data)
//   imm_dpl_e1                sign-extended 16-bit immediate
//   wreg_alu, alu_result_e1   E1 forwarding destination (0 = none) / result
//   op_e2, wreg_e2, result_e2 E2 opcode, write-back register and value
//
// Optional build macro DM_PROBE_EN adds dm_probe0/1/2, which continuously
// show data-memory words 133, 144 and 225.
// -----------------------------------------------------------------------------
module exec_mem_stage
  import exec_pkg::*;
#(
  parameter int DM_AW = 8
) (
  input  logic        sysclk,
  input  logic        cpu_resetn,
  input  logic [31:0] pc_e1,
  input  logic [5:0]  op_e1,
  input  logic [4:0]  rt_e1,
  input  logic [4:0]  rd_e1,
  input  logic [10:0] aux_e1,
  input  logic [31:0] os_e1,
  input  logic [31:0] ot_e1,
  input  logic [31:0] imm_dpl_e1,
  output logic [4:0]  wreg_alu,
  output logic [31:0] alu_result_e1,
  output logic [5:0]  op_e2,
  output logic [4:0]  wreg_e2,
  output logic [31:0] result_e2
`ifdef DM_PROBE_EN
  ,
  output logic [31:0] dm_probe0,
  output logic [31:0] dm_probe1,
  output logic [31:0] dm_probe2
`endif
);

`ifdef DM_PROBE_EN
  localparam int NRD = 4;
`else
  localparam int NRD = 1;
`endif

  // ---------------------------------------------------------------------------
  // E1: combinational ALU
  // ---------------------------------------------------------------------------
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_zx;
  logic [31:0] alu_d;
  logic [4:0]  dest_d;

  assign shamt  = aux_e1[10:6];
  assign funct  = aux_e1[5:0];
  assign imm_zx = {16'h0000, imm_dpl_e1[15:0]};

  // NOTE: every output of this block gets a default first, so no path through
  // the case statements leaves a variable unassigned and no latch is inferred.
  always_comb begin
    alu_d  = '0;
    dest_d = '0;
    case (op_e1)
      OP_RTYPE: begin
        dest_d = rd_e1;
        case (funct)
          FN_ADD:  alu_d = os_e1 + ot_e1;
          FN_SUB:  alu_d = os_e1 - ot_e1;
          FN_AND:  alu_d = os_e1 & ot_e1;
          FN_OR:   alu_d = os_e1 | ot_e1;
          FN_XOR:  alu_d = os_e1 ^ ot_e1;
          FN_NOR:  alu_d = ~(os_e1 | ot_e1);
          FN_SLL:  alu_d = ot_e1 << shamt;
          FN_SRL:  alu_d = ot_e1 >> shamt;
          FN_SRA:  alu_d = $signed(ot_e1) >>> shamt;
          default: dest_d = '0;
        endcase
      end
      OP_ADDI: begin
        alu_d  = os_e1 + imm_dpl_e1;
        dest_d = rt_e1;
      end
      OP_LUI: begin
        alu_d  = {imm_dpl_e1[15:0], 16'h0000};
        dest_d = rt_e1;
      end
      OP_ANDI: begin
        alu_d  = os_e1 & imm_zx;
        dest_d = rt_e1;
      end
      OP_ORI: begin
        alu_d  = os_e1 | imm_zx;
        dest_d = rt_e1;
      end
      OP_XORI: begin
        alu_d  = os_e1 ^ imm_zx;
        dest_d = rt_e1;
      end
      OP_LW, OP_LH, OP_LB: begin
        alu_d  = os_e1 + imm_dpl_e1;
        dest_d = rt_e1;
      end
      OP_SW, OP_SH, OP_SB: begin
        alu_d = os_e1 + imm_dpl_e1;
      end
      OP_JAL: begin
        alu_d  = pc_e1 + 32'd1;
        dest_d = 5'd31;
      end
      default: begin
        alu_d  = '0;
        dest_d = '0;
      end
    endcase
  end

  // Load data only exists after E2, so a load offers nothing to forward here.
  assign wreg_alu      = is_load(op_e1) ? 5'd0 : dest_d;
  assign alu_result_e1 = alu_d;

  // ---------------------------------------------------------------------------
  // E1 -> E2 register. For loads and stores the ALU result is the byte
  // address, so alu_q doubles as the E2 memory address.
  // ---------------------------------------------------------------------------
  logic [5:0]  op_q;
  logic [4:0]  dest_q;
  logic [31:0] alu_q;
  logic [31:0] ot_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      op_q   <= '0;
      dest_q <= '0;
      alu_q  <= '0;
      ot_q   <= '0;
    end else begin
      op_q   <= op_e1;
      dest_q <= dest_d;
      alu_q  <= alu_d;
      ot_q   <= ot_e1;
    end
  end

  // ---------------------------------------------------------------------------
  // E2: data memory, four little-endian byte lanes
  // ---------------------------------------------------------------------------
  size_e                       size_e2;
  logic [DM_AW-1:0]            word_idx;
  logic [1:0]                  byte_off;
  logic [3:0]                  lane_we;
  logic [31:0]                 lane_wdata;
  logic [NRD-1:0][DM_AW-1:0]   rd_idx;
  logic [3:0][NRD-1:0][7:0]    lane_rd;

  assign size_e2  = mem_size(op_q);
  assign word_idx = alu_q[DM_AW+1:2];  // upper address bits wrap
  assign byte_off = alu_q[1:0];

  // Store lane enables; cpu_resetn gating keeps a store caught by reset from
  // committing even if the edge and the reset assertion coincide.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = ot_q;
    if (is_store(op_q) && cpu_resetn) begin
      case (size_e2)
        SZ_WORD: lane_we = 4'b1111;
        SZ_HALF: begin
          lane_we    = alu_q[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{ot_q[15:0]}};
        end
        SZ_BYTE: begin
          lane_we    = 4'b0001 << byte_off;
          lane_wdata = {4{ot_q[7:0]}};
        end
        default: lane_we = 4'b0000;
      endcase
    end
  end

  assign rd_idx[0] = word_idx;
`ifdef DM_PROBE_EN
  assign rd_idx[1] = DM_AW'(DM_PROBE_WORD0);
  assign rd_idx[2] = DM_AW'(DM_PROBE_WORD1);
  assign rd_idx[3] = DM_AW'(DM_PROBE_WORD2);
`endif

  for (genvar k = 0; k < 4; k++) begin : g_lane
    dm_lane #(
      .AW  (DM_AW),
      .NRD (NRD)
    ) u_lane (
      .sysclk  (sysclk),
      .we_i    (lane_we[k]),
      .waddr_i (word_idx),
      .wdata_i (lane_wdata[8*k +: 8]),
      .raddr_i (rd_idx),
      .rdata_o (lane_rd[k])
    );
  end

`ifdef DM_PROBE_EN
  assign dm_probe0 = {lane_rd[3][1], lane_rd[2][1], lane_rd[1][1], lane_rd[0][1]};
  assign dm_probe1 = {lane_rd[3][2], lane_rd[2][2], lane_rd[1][2], lane_rd[0][2]};
  assign dm_probe2 = {lane_rd[3][3], lane_rd[2][3], lane_rd[1][3], lane_rd[0][3]};
`endif

  // ---------------------------------------------------------------------------
  // E2: load extraction and write-back mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] load_data;

  assign rd_word = {lane_rd[3][0], lane_rd[2][0], lane_rd[1][0], lane_rd[0][0]};
  assign rd_half = alu_q[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = 8'(rd_word >> {byte_off, 3'b000});

  always_comb begin
    load_data = rd_word;
    case (size_e2)
      SZ_HALF: load_data = {{16{rd_half[15]}}, rd_half};
      SZ_BYTE: load_data = {{24{rd_byte[7]}}, rd_byte};
      default: load_data = rd_word;
    endcase
  end

  assign op_e2     = op_q;
  assign wreg_e2   = dest_q;
  assign result_e2 = is_load(op_q) ? load_data : alu_q;

endmodule

// File: tb/tb_exec_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_exec_mem_stage
// Self-checking bench for exec_mem_stage. A behavioural model (ALU rules as
// plain arithmetic, data memory as a flat byte array) predicts E1 outputs for
// the instruction being issued and E2 outputs for the one issued before it.
// Define DM_PROBE_EN to also check the probe outputs.
// -----------------------------------------------------------------------------
module tb_exec_mem_stage;

  logic        sysclk = 1'b0;
  logic        cpu_resetn;
  logic [31:0] pc_e1, os_e1, ot_e1, imm_dpl_e1;
  logic [5:0]  op_e1;
  logic [4:0]  rt_e1, rd_e1;
  logic [10:0] aux_e1;
  logic [4:0]  wreg_alu, wreg_e2;
  logic [31:0] alu_result_e1, result_e2;
  logic [5:0]  op_e2;
`ifdef DM_PROBE_EN
  logic [31:0] dm_probe0, dm_probe1, dm_probe2;
`endif

  always #5 sysclk = ~sysclk;

  exec_mem_stage #(.DM_AW(8)) dut (
    .sysclk        (sysclk),
    .cpu_resetn    (cpu_resetn),
    .pc_e1         (pc_e1),
    .op_e1         (op_e1),
    .rt_e1         (rt_e1),
    .rd_e1         (rd_e1),
    .aux_e1        (aux_e1),
    .os_e1         (os_e1),
    .ot_e1         (ot_e1),
    .imm_dpl_e1    (imm_dpl_e1),
    .wreg_alu      (wreg_alu),
    .alu_result_e1 (alu_result_e1),
    .op_e2         (op_e2),
    .wreg_e2       (wreg_e2),
    .result_e2     (result_e2)
`ifdef DM_PROBE_EN
    ,
    .dm_probe0     (dm_probe0),
    .dm_probe1     (dm_probe1),
    .dm_probe2     (dm_probe2)
`endif
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] os, ot, pc;
    logic [15:0] imm;
  } instr_t;

  // What E2 is expected to hold: the previously issued instruction
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  dest;
    logic [31:0] alu, ot;
  } pend_t;

  logic [7:0] ref_mem [1024];  // 256 words x 4 bytes, byte-addressed
  pend_t      pend;
  int         n_checks = 0;
  int         n_pass   = 0;

  localparam pend_t PEND_ZERO = '{op: 6'd0, dest: 5'd0, alu: 32'd0, ot: 32'd0};

  function automatic instr_t mk(input int op, input int rt, input int rd, input int shamt,
                                input int funct, input logic [31:0] os, input logic [31:0] ot,
                                input int imm, input logic [31:0] pc);
    instr_t t;
    t.op = 6'(op); t.rt = 5'(rt); t.rd = 5'(rd); t.shamt = 5'(shamt); t.funct = 6'(funct);
    t.os = os; t.ot = ot; t.imm = 16'(imm); t.pc = pc;
    return t;
  endfunction

  function automatic logic is_ld(input logic [5:0] op);
    return op == 6'd16 || op == 6'd18 || op == 6'd20;
  endfunction

  function automatic logic is_st(input logic [5:0] op);
    return op == 6'd24 || op == 6'd26 || op == 6'd28;
  endfunction

  // Reference E1: result, E2 destination and forwardable destination
  function automatic void ref_e1(input instr_t t, output logic [31:0] res,
                                 output logic [4:0] d2, output logic [4:0] d1);
    logic [31:0] sx, zx;
    sx = {{16{t.imm[15]}}, t.imm};
    zx = {16'd0, t.imm};
    res = 0; d2 = 0;
    case (t.op)
      0: begin
        d2 = t.rd;
        case (t.funct)
          0:  res = t.os + t.ot;
          2:  res = t.os - t.ot;
          8:  res = t.os & t.ot;
          9:  res = t.os | t.ot;
          10: res = t.os ^ t.ot;
          11: res = ~(t.os | t.ot);
          16: res = t.ot << t.shamt;
          17: res = t.ot >> t.shamt;
          18: res = 32'($signed(t.ot) >>> t.shamt);
          default: d2 = 0;
        endcase
      end
      1:  begin res = t.os + sx; d2 = t.rt; end
      3:  begin res = zx * 32'd65536; d2 = t.rt; end
      4:  begin res = t.os & zx; d2 = t.rt; end
      5:  begin res = t.os | zx; d2 = t.rt; end
      6:  begin res = t.os ^ zx; d2 = t.rt; end
      16, 18, 20: begin res = t.os + sx; d2 = t.rt; end
      24, 26, 28: res = t.os + sx;
      41: begin res = t.pc + 1; d2 = 31; end
      default: ;
    endcase
    d1 = is_ld(t.op) ? 5'd0 : d2;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'(addr[9:0]) & ~3;
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
    int a;
    a = int'(addr[9:0]);
    case (op)
      16: return ref_word(addr);
      18: begin
        a = a & ~1;
        return {{16{ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
      end
      default: return {{24{ref_mem[a][7]}}, ref_mem[a]};
    endcase
  endfunction

  function automatic void ref_store(input logic [5:0] op, input logic [31:0] addr,
                                    input logic [31:0] d);
    int a;
    a = int'(addr[9:0]);
    case (op)
      24: begin
        a = a & ~3;
        for (int i = 0; i < 4; i++) ref_mem[a+i] = d[8*i +: 8];
      end
      26: begin
        a = a & ~1;
        ref_mem[a] = d[7:0];
        ref_mem[a+1] = d[15:8];
      end
      default: ref_mem[a] = d[7:0];
    endcase
  endfunction

  // Issue one instruction into E1 (called just after a rising edge). Checks
  // its E1 outputs and the E2 outputs of the previous instruction.
  task automatic issue(input instr_t t);
    logic [31:0] res, exp2;
    logic [4:0]  d2, d1;
    pc_e1 = t.pc; op_e1 = t.op; rt_e1 = t.rt; rd_e1 = t.rd;
    aux_e1 = {t.shamt, t.funct}; os_e1 = t.os; ot_e1 = t.ot;
    imm_dpl_e1 = {{16{t.imm[15]}}, t.imm};
    ref_e1(t, res, d2, d1);
    @(negedge sysclk);
    n_checks++;
    if (alu_result_e1 !== res)
      $display("FAIL alu_result_e1 op=%0d funct=%0d: got %h want %h", t.op, t.funct, alu_result_e1, res);
    else n_pass++;
    n_checks++;
    if (wreg_alu !== d1)
      $display("FAIL wreg_alu op=%0d funct=%0d: got %0d want %0d", t.op, t.funct, wreg_alu, d1);
    else n_pass++;
    exp2 = is_ld(pend.op) ? ref_load(pend.op, pend.alu) : pend.alu;
    n_checks++;
    if (op_e2 !== pend.op) $display("FAIL op_e2: got %0d want %0d", op_e2, pend.op);
    else n_pass++;
    n_checks++;
    if (wreg_e2 !== pend.dest)
      $display("FAIL wreg_e2 op=%0d: got %0d want %0d", pend.op, wreg_e2, pend.dest);
    else n_pass++;
    n_checks++;
    if (result_e2 !== exp2)
      $display("FAIL result_e2 op=%0d addr=%h: got %h want %h", pend.op, pend.alu, result_e2, exp2);
    else n_pass++;
`ifdef DM_PROBE_EN
    n_checks++;
    if (dm_probe0 !== ref_word(32'd532)) $display("FAIL dm_probe0: got %h want %h", dm_probe0, ref_word(32'd532));
    else n_pass++;
    n_checks++;
    if (dm_probe1 !== ref_word(32'd576)) $display("FAIL dm_probe1: got %h want %h", dm_probe1, ref_word(32'd576));
    else n_pass++;
    n_checks++;
    if (dm_probe2 !== ref_word(32'd900)) $display("FAIL dm_probe2: got %h want %h", dm_probe2, ref_word(32'd900));
    else n_pass++;
`endif
    // A store in E2 commits at the coming edge, after this comparison point
    if (is_st(pend.op)) ref_store(pend.op, pend.alu, pend.ot);
    @(posedge sysclk);
    #1;
    pend = '{op: t.op, dest: d2, alu: res, ot: t.ot};
  endtask

  function automatic instr_t nop();
    return mk(32, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic test_reset();
    cpu_resetn = 1'b0;
    pc_e1 = 0; op_e1 = 0; rt_e1 = 0; rd_e1 = 0; aux_e1 = 0;
    os_e1 = 0; ot_e1 = 0; imm_dpl_e1 = 0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    n_checks++;
    if (op_e2 !== 6'd0) $display("FAIL reset op_e2: got %0d want 0", op_e2); else n_pass++;
    n_checks++;
    if (wreg_e2 !== 5'd0) $display("FAIL reset wreg_e2: got %0d want 0", wreg_e2); else n_pass++;
    n_checks++;
    if (result_e2 !== 32'd0) $display("FAIL reset result_e2: got %h want 0", result_e2); else n_pass++;
    cpu_resetn = 1'b1;
    @(posedge sysclk);
    #1;
    n_checks++;
    if (wreg_e2 !== 5'd0 || result_e2 !== 32'd0 || op_e2 !== 6'd0)
      $display("FAIL release E2: got op=%0d wreg=%0d res=%h want all 0", op_e2, wreg_e2, result_e2);
    else n_pass++;
    pend = PEND_ZERO;
  endtask

  task automatic test_alu();
    issue(mk(0, 0, 9, 0, 0, 5, 7, 0, 0));                 // add -> 12, rd 9
    issue(mk(0, 0, 3, 4, 18, 0, 32'h8000_0000, 0, 0));    // sra -> F8000000
    issue(mk(0, 0, 6, 0, 63, 1, 2, 0, 0));                // unknown funct -> 0, 0
    for (int i = 0; i < 30; i++) begin
      int fl [10] = '{0, 2, 8, 9, 10, 11, 16, 17, 18, 5};
      issue(mk(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               fl[$urandom_range(0, 9)], $urandom, $urandom, 0, 0));
      issue(mk($urandom_range(1, 6), $urandom_range(0, 31), 0, 0, 0, $urandom, 0, $urandom, 0));
    end
  endtask

  task automatic test_lui_jal();
    issue(mk(3, 4, 0, 0, 0, 32'hFFFF_FFFF, 0, 16'h1234, 0));
    issue(mk(41, 0, 0, 0, 0, 0, 0, 0, 20));
    issue(mk(41, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF));  // wraps to 0
  endtask

  task automatic test_word_mem();
    issue(mk(24, 7, 0, 0, 0, 0, 32'h315, 532, 0));  // sw
    issue(mk(16, 12, 0, 0, 0, 0, 0, 532, 0));       // lw right behind the store
    issue(nop());
  endtask

  task automatic test_byte_half();
    issue(mk(28, 0, 0, 0, 0, 0, 32'h1234_56AB, 3, 0));  // sb 0xAB @3
    issue(mk(16, 1, 0, 0, 0, 0, 0, 3, 0));              // lw -> AB000000
    issue(mk(20, 2, 0, 0, 0, 0, 0, 3, 0));              // lb -> FFFFFFAB
    issue(mk(26, 0, 0, 0, 0, 0, 32'h5555_8001, 2, 0));  // sh 0x8001 @2
    issue(mk(18, 3, 0, 0, 0, 0, 0, 2, 0));              // lh -> FFFF8001
    issue(mk(18, 4, 0, 0, 0, 3, 0, 0, 0));              // lh @3: bit0 ignored
    issue(mk(20, 5, 0, 0, 0, 1, 0, 0, 0));              // lb @1 -> 0
    issue(nop());
  endtask

  task automatic test_wrap();
    issue(mk(24, 0, 0, 0, 0, 1024, 32'hCAFE_F00D, 8, 0));  // byte 1032 -> word 2
    issue(mk(16, 8, 0, 0, 0, 0, 0, 8, 0));
    issue(mk(24, 0, 0, 0, 0, 0, 987, 576, 0));             // probe word 144
    issue(nop());
    issue(nop());
  endtask

  task automatic test_reset_mid_store();
    issue(mk(24, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 40, 0));  // store now in E2
    op_e1 = 6'd32;
    #2 cpu_resetn = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if (op_e2 !== 6'd0 || wreg_e2 !== 5'd0 || result_e2 !== 32'd0)
      $display("FAIL mid-reset E2 clear: got op=%0d wreg=%0d res=%h want all 0", op_e2, wreg_e2, result_e2);
    else n_pass++;
    @(posedge sysclk);
    #1 cpu_resetn = 1'b1;
    pend = PEND_ZERO;  // the store was squashed and must not reach memory
    issue(mk(16, 9, 0, 0, 0, 40, 0, 0, 0));
    issue(nop());
  endtask

  task automatic test_random_mix();
    int ops [18] = '{0, 1, 3, 4, 5, 6, 16, 18, 20, 24, 26, 28, 41, 32, 40, 42, 63, 7};
    for (int i = 0; i < 400; i++) begin
      issue(mk(ops[$urandom_range(0, 17)], $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 18), $urandom_range(0, 127), $urandom,
               ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 127), $urandom));
    end
    issue(nop());
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_alu();
    test_lui_jal();
    test_word_mem();
    test_byte_half();
    test_wrap();
    test_reset_mid_store();
    test_random_mix();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
